// File: rtl/sw_debounce_enable_pkg.sv
// Shared constants for the switch debounce / enable conditioning block.
// DB_10MS is the 10 ms qualification period at 100 MHz; DB_SIM shortens it for simulation.
package sw_debounce_enable_pkg;

  localparam int DB_10MS   = 1_000_000;
  localparam int DB_SIM    = 4;
  localparam int CNT_W_DEF = 20;

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: 2-FF synchronizer, stability counter, rise/fall strobes
// and an enable output that either follows the debounced level or toggles on press.
module sw_debounce_chan
  import sw_debounce_enable_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DB_COUNT = DB_10MS,
  parameter bit TOGGLE   = 1'b0
) (
  input  logic sysclk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic enable
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DB_COUNT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             r_enable;

  logic w_differ;
  logic w_accept;
  logic w_enable_nxt;

  assign w_differ = (r_sync2 != r_level);
  assign w_accept = w_differ && (r_cnt == LP_CNT_MAX);

  // Level mode loads the same value as r_level so both registers switch together.
  assign w_enable_nxt = TOGGLE ? (r_enable ^ (w_accept & r_sync2))
                               : (w_accept ? r_sync2 : r_level);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_cnt    <= '0;
      r_level  <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_enable <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (!w_differ || w_accept) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_level <= r_sync2;
      end
      r_rise   <= w_accept &  r_sync2;
      r_fall   <= w_accept & ~r_sync2;
      r_enable <= w_enable_nxt;
    end
  end

  assign level  = r_level;
  assign rise   = r_rise;
  assign fall   = r_fall;
  assign enable = r_enable;

endmodule

// File: rtl/sw_debounce_enable.sv
// Board switch conditioning ahead of the PWM / breathing-LED stages: one
// independent debounce channel per pin, toggle or level enable chosen per bit.
module sw_debounce_enable
  import sw_debounce_enable_pkg::*;
#(
  parameter int                NUM_SW      = 4,
  parameter int                CNT_W       = CNT_W_DEF,
  parameter int                DB_COUNT    = DB_10MS,
  parameter logic [NUM_SW-1:0] TOGGLE_MASK = '0
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [NUM_SW-1:0] SW_raw,
  output logic [NUM_SW-1:0] SW_level,
  output logic [NUM_SW-1:0] SW_rise,
  output logic [NUM_SW-1:0] SW_fall,
  output logic [NUM_SW-1:0] Enable
);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
    sw_debounce_chan #(
      .CNT_W    (CNT_W),
      .DB_COUNT (DB_COUNT),
      .TOGGLE   (TOGGLE_MASK[g])
    ) u_chan (
      .sysclk (sysclk),
      .reset  (reset),
      .raw    (SW_raw[g]),
      .level  (SW_level[g]),
      .rise   (SW_rise[g]),
      .fall   (SW_fall[g]),
      .enable (Enable[g])
    );
  end

endmodule
